stopwatch_tick_counter: RTL and testbench

//   Consumes the toggling slow clocks from the clock divider as events in the 100 MHz

---
 rtl/stopwatch_tick_counter.sv | 237 +++++++++++++++++++++++
 tb/tb_stopwatch_tick_counter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_tick_counter.sv
// stopwatch_tick_counter
//   BCD MM:SS stopwatch driven by the toggling 1 Hz / 2 Hz divider outputs.
//   Every level transition of a tick input is one event in the clock_in domain.
//   Supports run/pause on the rising edge of pause, clear, and per-field adjust.
//
// Configuration macro:
//   TICK_SYNC_EN  defined   -> 2-flop synchronizer on both tick inputs,
//                              tick change to count update = 3 cycles
//                 undefined -> ticks sampled directly as synchronous inputs,
//                              tick change to count update = 1 cycle

module stopwatch_tick_counter #(
  parameter int MIN_WRAP     = 59,   // last minutes value, BCD-legal 1..99
  parameter bit ADJ_TICK_SEL = 1'b1  // adjust event source: 1 = tick_2hz, 0 = tick_1hz
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause,
  input  logic       clear,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       tick_evt
);

  // Minutes wrap point split into its two BCD digits.
  localparam logic [3:0] MIN_WRAP_TENS = 4'(MIN_WRAP / 10);
  localparam logic [3:0] MIN_WRAP_ONES = 4'(MIN_WRAP % 10);

  // Run/pause state.
  typedef enum logic {
    ST_PAUSED  = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_t;

  run_state_t run_state;
  run_state_t run_state_d;

  // Tick levels as seen by the edge detectors.
  logic tick_1hz_s;
  logic tick_2hz_s;

  // Registered copies used for both-edge detection.
  logic prev_1hz;
  logic prev_2hz;

  // Warm-up counter: events stay masked until the detect pipeline holds
  // only post-reset samples, so nothing left over from before reset fires.
  logic [1:0] warm_cnt;
  logic       events_armed;

  logic evt_1hz;
  logic evt_2hz;
  logic adj_evt;

  logic pause_q;
  logic pause_rise;

  // Incremented versions of the current fields.
  logic [3:0] sec_tens_inc;
  logic [3:0] sec_ones_inc;
  logic       sec_at_max;
  logic [3:0] min_tens_inc;
  logic [3:0] min_ones_inc;
  logic       min_at_wrap;

  // Next-state of the visible count.
  logic [3:0] min_tens_d;
  logic [3:0] min_ones_d;
  logic [3:0] sec_tens_d;
  logic [3:0] sec_ones_d;
  logic       count_applied;

`ifdef TICK_SYNC_EN
  localparam logic [1:0] WARM_CYCLES = 2'd3;

  logic [1:0] sync_1hz;
  logic [1:0] sync_2hz;

  // Two-flop synchronizers; the divider outputs are treated as asynchronous.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_1hz <= 2'b00;
      sync_2hz <= 2'b00;
    end else begin
      sync_1hz <= {sync_1hz[0], tick_1hz};
      sync_2hz <= {sync_2hz[0], tick_2hz};
    end
  end

  assign tick_1hz_s = sync_1hz[1];
  assign tick_2hz_s = sync_2hz[1];
`else
  localparam logic [1:0] WARM_CYCLES = 2'd1;

  assign tick_1hz_s = tick_1hz;
  assign tick_2hz_s = tick_2hz;
`endif

  // Count the first few cycles after reset release, then stay armed.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= 2'd0;
    end else if (warm_cnt != WARM_CYCLES) begin
      warm_cnt <= warm_cnt + 2'd1;
    end
  end

  assign events_armed = (warm_cnt == WARM_CYCLES);

  // Previous-level registers for tick and pause edge detection.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      prev_1hz <= 1'b0;
      prev_2hz <= 1'b0;
      pause_q  <= 1'b0;
    end else begin
      prev_1hz <= tick_1hz_s;
      prev_2hz <= tick_2hz_s;
      pause_q  <= pause;
    end
  end

  assign evt_1hz    = events_armed & (tick_1hz_s ^ prev_1hz);
  assign evt_2hz    = events_armed & (tick_2hz_s ^ prev_2hz);
  assign adj_evt    = ADJ_TICK_SEL ? evt_2hz : evt_1hz;
  assign pause_rise = pause & ~pause_q;

  // Run/pause state register.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      run_state <= ST_PAUSED;
    end else begin
      run_state <= run_state_d;
    end
  end

  // Each pause rising edge flips between paused and running.
  always_comb begin
    run_state_d = run_state;
    if (pause_rise) begin
      case (run_state)
        ST_PAUSED: run_state_d = ST_RUNNING;
        default:   run_state_d = ST_PAUSED;
      endcase
    end
  end

  // The count logic sees the pre-toggle state, so a coincident tick uses it.
  assign running = (run_state == ST_RUNNING);

  // Seconds +1 in BCD, wrapping 59 -> 00 and flagging the wrap as a carry.
  always_comb begin
    sec_ones_inc = sec_ones + 4'd1;
    sec_tens_inc = sec_tens;
    sec_at_max   = (sec_tens == 4'd5) && (sec_ones == 4'd9);
    if (sec_ones == 4'd9) begin
      sec_ones_inc = 4'd0;
      if (sec_tens == 4'd5) begin
        sec_tens_inc = 4'd0;
      end else begin
        sec_tens_inc = sec_tens + 4'd1;
      end
    end
  end

  // Minutes +1 in BCD, wrapping MIN_WRAP -> 00.
  always_comb begin
    min_ones_inc = min_ones + 4'd1;
    min_tens_inc = min_tens;
    min_at_wrap  = (min_tens == MIN_WRAP_TENS) && (min_ones == MIN_WRAP_ONES);
    if (min_at_wrap) begin
      min_ones_inc = 4'd0;
      min_tens_inc = 4'd0;
    end else if (min_ones == 4'd9) begin
      min_ones_inc = 4'd0;
      min_tens_inc = min_tens + 4'd1;
    end
  end

  // Choose the next count: clear beats adjust, adjust beats normal counting.
  always_comb begin
    min_tens_d    = min_tens;
    min_ones_d    = min_ones;
    sec_tens_d    = sec_tens;
    sec_ones_d    = sec_ones;
    count_applied = 1'b0;
    if (clear) begin
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (adj) begin
      if (adj_evt) begin
        if (sel) begin
          sec_tens_d = sec_tens_inc;
          sec_ones_d = sec_ones_inc;
        end else begin
          min_tens_d = min_tens_inc;
          min_ones_d = min_ones_inc;
        end
      end
    end else if (running && evt_1hz) begin
      sec_tens_d    = sec_tens_inc;
      sec_ones_d    = sec_ones_inc;
      count_applied = 1'b1;
      if (sec_at_max) begin
        min_tens_d = min_tens_inc;
        min_ones_d = min_ones_inc;
      end
    end
  end

  // Count digits and the one-cycle count-applied pulse.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      tick_evt <= 1'b0;
    end else begin
      min_tens <= min_tens_d;
      min_ones <= min_ones_d;
      sec_tens <= sec_tens_d;
      sec_ones <= sec_ones_d;
      tick_evt <= count_applied;
    end
  end

endmodule

// File: tb/tb_stopwatch_tick_counter.sv
// tb_stopwatch_tick_counter
//   Directed bench for stopwatch_tick_counter with default parameters
//   (MIN_WRAP = 59, adjust driven by tick_2hz). Follows TICK_SYNC_EN for latency.

`timescale 1ns/1ps

module tb_stopwatch_tick_counter;

`ifdef TICK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clock_in;
  logic        reset_n;
  logic        tick_1hz;
  logic        tick_2hz;
  logic        pause;
  logic        clear;
  logic        adj;
  logic        sel;
  logic [3:0]  min_tens;
  logic [3:0]  min_ones;
  logic [3:0]  sec_tens;
  logic [3:0]  sec_ones;
  logic        running;
  logic        tick_evt;
  logic [15:0] digits;

  int vectors       = 0;
  int miscompares   = 0;
  int evt_seen      = 0;
  int evt_misplaced = 0;
  int evt_sum       = 0;
  int nonzero_seen  = 0;

  stopwatch_tick_counter dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .tick_1hz (tick_1hz),
    .tick_2hz (tick_2hz),
    .pause    (pause),
    .clear    (clear),
    .adj      (adj),
    .sel      (sel),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .tick_evt (tick_evt)
  );

  assign digits = {min_tens, min_ones, sec_tens, sec_ones};

  // 100 MHz clock.
  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Advance n clock edges, leaving the bench 1 ns past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Toggle the chosen tick inputs and wait out the detect latency,
  // tallying tick_evt pulses and noting any that land off-cycle.
  task automatic applyStimulus(input logic do_1hz, input logic do_2hz);
    if (do_1hz) tick_1hz = ~tick_1hz;
    if (do_2hz) tick_2hz = ~tick_2hz;
    for (int k = 1; k <= LAT; k++) begin
      step(1);
      if (tick_evt) begin
        evt_seen++;
        if (k != LAT) evt_misplaced++;
      end
    end
  endtask

  // One-cycle pause pulse.
  task automatic pulsePause();
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    step(1);
  endtask

  initial begin
    reset_n  = 1'b0;
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
    pause    = 1'b0;
    clear    = 1'b0;
    adj      = 1'b0;
    sel      = 1'b0;
    step(2);

    // 1. Ticks toggling under reset must not move anything.
    for (int i = 0; i < 4; i++) begin
      tick_1hz = ~tick_1hz;
      tick_2hz = ~tick_2hz;
      step(1);
      if (digits != 16'h0000) nonzero_seen++;
      if (tick_evt) evt_sum++;
    end
    checkOutput("reset_digits", digits, 16'h0000);
    checkOutput("reset_running", running, 0);
    checkOutput("reset_nonzero", nonzero_seen, 0);
    checkOutput("reset_evt", evt_sum, 0);
    tick_1hz = 1'b1;
    reset_n  = 1'b1;
    evt_sum  = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (tick_evt) evt_sum++;
    end
    checkOutput("release_digits", digits, 16'h0000);
    checkOutput("release_evt", evt_sum, 0);

    // 2. Start running, 60 one-second toggles -> 01:00.
    pulsePause();
    checkOutput("run_after_pause", running, 1);
    evt_seen      = 0;
    evt_misplaced = 0;
    tick_1hz = ~tick_1hz;
    step(LAT - 1);
    checkOutput("latency_early_digits", digits, 16'h0000);
    checkOutput("latency_early_evt", tick_evt, 0);
    step(1);
    checkOutput("latency_digits", digits, 16'h0001);
    checkOutput("latency_evt", tick_evt, 1);
    if (tick_evt) evt_seen++;
    for (int i = 0; i < 59; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("count_60", digits, 16'h0100);
    checkOutput("evt_count_60", evt_seen, 60);
    checkOutput("evt_timing", evt_misplaced, 0);

    // 3. Preload through adjust, including the minutes wrap, then 59:59 -> 00:00.
    evt_seen = 0;
    adj = 1'b1;
    sel = 1'b0;
    for (int i = 0; i < 58; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("adj_min_59", digits, 16'h5900);
    applyStimulus(1'b0, 1'b1);
    checkOutput("adj_min_wrap", digits, 16'h0000);
    for (int i = 0; i < 59; i++) applyStimulus(1'b0, 1'b1);
    sel = 1'b1;
    for (int i = 0; i < 59; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("preload_5959", digits, 16'h5959);
    checkOutput("adj_no_evt", evt_seen, 0);
    adj = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("wrap_5959", digits, 16'h0000);
    checkOutput("wrap_evt", tick_evt, 1);

    // 4. Seconds adjust 58 -> 01 without carry; 1 Hz ignored in adjust.
    evt_seen = 0;
    adj = 1'b1;
    sel = 1'b0;
    applyStimulus(1'b0, 1'b1);
    sel = 1'b1;
    for (int i = 0; i < 58; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("adj_sec_58", digits, 16'h0158);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("adj_sec_nocarry", digits, 16'h0101);
    applyStimulus(1'b1, 1'b1);
    checkOutput("adj_both_ticks", digits, 16'h0102);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("adj_1hz_ignored", digits, 16'h0102);
    checkOutput("adj_no_evt2", evt_seen, 0);
    checkOutput("adj_running_kept", running, 1);
    adj = 1'b0;

    // 5. Pause edge coincident with a tick event: count first, then stop.
    tick_1hz = ~tick_1hz;
    step(LAT - 1);
    pause = 1'b1;
    step(1);
    checkOutput("coincide_digits", digits, 16'h0103);
    checkOutput("coincide_evt", tick_evt, 1);
    checkOutput("coincide_running", running, 0);
    pause = 1'b0;
    step(1);
    evt_seen = 0;
    applyStimulus(1'b1, 1'b0);
    step(1);
    checkOutput("paused_digits", digits, 16'h0103);
    checkOutput("paused_evt", evt_seen, 0);
    pause = 1'b1;
    step(5);
    checkOutput("pause_hold_once", running, 1);
    pause = 1'b0;
    step(1);

    // 6. Clear during an event, then reset in the middle of counting.
    tick_1hz = ~tick_1hz;
    step(LAT - 1);
    clear = 1'b1;
    step(1);
    checkOutput("clear_digits", digits, 16'h0000);
    checkOutput("clear_running", running, 1);
    checkOutput("clear_evt", tick_evt, 0);
    clear = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("after_clear_count", digits, 16'h0001);
    tick_1hz = ~tick_1hz;
    step(1);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_digits", digits, 16'h0000);
    checkOutput("midreset_running", running, 0);
    checkOutput("midreset_evt", tick_evt, 0);
    step(2);
    reset_n = 1'b1;
    evt_sum = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (tick_evt) evt_sum++;
    end
    checkOutput("postreset_digits", digits, 16'h0000);
    checkOutput("postreset_evt", evt_sum, 0);
    pulsePause();
    applyStimulus(1'b1, 1'b0);
    checkOutput("postreset_count", digits, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
